// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: latches MEM results, extracts load data,
// generates link addresses, drives the GPR write port and holds architectural HI/LO.
module wb_stage #(
  parameter int unsigned LINK_OFFSET = 8,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [7:0]  mem_inst_name,
  input  logic [31:0] mem_pc,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_addr_low,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_load_ext,
  input  logic [31:0] mem_hi_wdata,
  input  logic [31:0] mem_lo_wdata,
  input  logic [31:0] mem_cp0_rdata,
  output logic [7:0]  wb_inst_name,
  input  logic [1:0]  memToReg,
  input  logic        regwrite,
  input  logic        HI_read,
  input  logic        HI_write,
  input  logic        LO_read,
  input  logic        LO_write,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic        valid_q,     valid_d;
  logic [7:0]  inst_name_q, inst_name_d;
  logic [31:0] pc_q,        pc_d;
  logic [4:0]  waddr_q,     waddr_d;
  logic [31:0] result_q,    result_d;
  logic [31:0] rdata_q,     rdata_d;
  logic [1:0]  addr_low_q,  addr_low_d;
  logic        is_load_q,   is_load_d;
  logic [2:0]  load_ext_q,  load_ext_d;
  logic [31:0] hi_wdata_q,  hi_wdata_d;
  logic [31:0] lo_wdata_q,  lo_wdata_d;
  logic [31:0] cp0_rdata_q, cp0_rdata_d;
  logic [31:0] hi_q,        hi_d;
  logic [31:0] lo_q,        lo_d;

  logic        commit;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] wdata_sel;

  // Reset blocks the commit in the same cycle it is asserted.
  assign commit = valid_q & ~stall & ~reset;

  // Pipeline register next state: reset > flush > stall > load.
  always_comb begin
    valid_d     = valid_q;
    inst_name_d = inst_name_q;
    pc_d        = pc_q;
    waddr_d     = waddr_q;
    result_d    = result_q;
    rdata_d     = rdata_q;
    addr_low_d  = addr_low_q;
    is_load_d   = is_load_q;
    load_ext_d  = load_ext_q;
    hi_wdata_d  = hi_wdata_q;
    lo_wdata_d  = lo_wdata_q;
    cp0_rdata_d = cp0_rdata_q;
    if (reset) begin
      valid_d     = 1'b0;
      inst_name_d = 8'd0;
      pc_d        = RESET_PC;
      waddr_d     = 5'd0;
      result_d    = 32'd0;
      rdata_d     = 32'd0;
      addr_low_d  = 2'd0;
      is_load_d   = 1'b0;
      load_ext_d  = 3'd0;
      hi_wdata_d  = 32'd0;
      lo_wdata_d  = 32'd0;
      cp0_rdata_d = 32'd0;
    end else if (flush) begin
      valid_d     = 1'b0;
      inst_name_d = 8'd0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      inst_name_d = mem_inst_name;
      pc_d        = mem_pc;
      waddr_d     = mem_waddr;
      result_d    = mem_result;
      rdata_d     = mem_rdata;
      addr_low_d  = mem_addr_low;
      is_load_d   = mem_is_load;
      load_ext_d  = mem_load_ext;
      hi_wdata_d  = mem_hi_wdata;
      lo_wdata_d  = mem_lo_wdata;
      cp0_rdata_d = mem_cp0_rdata;
    end
  end

  // Architectural HI/LO next state; MULT/DIV may write both at once.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (reset) begin
      hi_d = 32'd0;
      lo_d = 32'd0;
    end else begin
      if (commit && HI_write) hi_d = hi_wdata_q;
      if (commit && LO_write) lo_d = lo_wdata_q;
    end
  end

  // State registers; reset handling lives in the next-state logic.
  always_ff @(posedge clk) begin
    valid_q     <= valid_d;
    inst_name_q <= inst_name_d;
    pc_q        <= pc_d;
    waddr_q     <= waddr_d;
    result_q    <= result_d;
    rdata_q     <= rdata_d;
    addr_low_q  <= addr_low_d;
    is_load_q   <= is_load_d;
    load_ext_q  <= load_ext_d;
    hi_wdata_q  <= hi_wdata_d;
    lo_wdata_q  <= lo_wdata_d;
    cp0_rdata_q <= cp0_rdata_d;
    hi_q        <= hi_d;
    lo_q        <= lo_d;
  end

  // Little-endian load extraction; half alignment is checked upstream so addr_low[0] is unused.
  always_comb begin
    load_byte = 8'd0;
    unique case (addr_low_q)
      2'd0: load_byte = rdata_q[7:0];
      2'd1: load_byte = rdata_q[15:8];
      2'd2: load_byte = rdata_q[23:16];
      2'd3: load_byte = rdata_q[31:24];
      default: load_byte = 8'd0;
    endcase
    load_half = addr_low_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (load_ext_q)
      3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b010:  load_data = {24'd0, load_byte};
      3'b011:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {16'd0, load_half};
      default: load_data = rdata_q;
    endcase
  end

  // Writeback data select; HI takes precedence over LO when both reads are flagged.
  always_comb begin
    wdata_sel = 32'd0;
    unique case (memToReg)
      2'b00: wdata_sel = is_load_q ? load_data : result_q;
      2'b01: begin
        if (HI_read)      wdata_sel = hi_q;
        else if (LO_read) wdata_sel = lo_q;
        else              wdata_sel = 32'd0;
      end
      2'b10: wdata_sel = pc_q + 32'(LINK_OFFSET);
      2'b11: wdata_sel = cp0_rdata_q;
      default: wdata_sel = 32'd0;
    endcase
  end

  assign wb_valid     = valid_q;
  assign wb_inst_name = inst_name_q;
  assign wb_pc        = pc_q;
  assign rf_waddr     = waddr_q;
  // Bubbles present zero write data so the reset state reads back clean.
  assign rf_wdata     = valid_q ? wdata_sel : 32'd0;
  assign rf_we        = commit & regwrite & (waddr_q != 5'd0);
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage. The neighbouring control decoder is modelled by packing the
// writeback controls into the instruction code: [7:6] memToReg, [5] regwrite, [4] HI_read,
// [3] HI_write, [2] LO_read, [1] LO_write.
module tb_wb_stage;

  localparam logic [31:0] ResetPc = 32'hBFC00000;

  logic        clk;
  logic        reset, stall, flush;
  logic        mem_valid;
  logic [7:0]  mem_inst_name;
  logic [31:0] mem_pc, mem_result, mem_rdata, mem_hi_wdata, mem_lo_wdata, mem_cp0_rdata;
  logic [4:0]  mem_waddr;
  logic [1:0]  mem_addr_low;
  logic        mem_is_load;
  logic [2:0]  mem_load_ext;
  logic [7:0]  wb_inst_name;
  logic [1:0]  memToReg;
  logic        regwrite, HI_read, HI_write, LO_read, LO_write;
  logic        wb_valid;
  logic [31:0] wb_pc, rf_wdata, hi_out, lo_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;

  assign memToReg = wb_inst_name[7:6];
  assign regwrite = wb_inst_name[5];
  assign HI_read  = wb_inst_name[4];
  assign HI_write = wb_inst_name[3];
  assign LO_read  = wb_inst_name[2];
  assign LO_write = wb_inst_name[1];

  wb_stage #(
    .LINK_OFFSET(8),
    .RESET_PC   (ResetPc)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .mem_valid    (mem_valid),
    .mem_inst_name(mem_inst_name),
    .mem_pc       (mem_pc),
    .mem_waddr    (mem_waddr),
    .mem_result   (mem_result),
    .mem_rdata    (mem_rdata),
    .mem_addr_low (mem_addr_low),
    .mem_is_load  (mem_is_load),
    .mem_load_ext (mem_load_ext),
    .mem_hi_wdata (mem_hi_wdata),
    .mem_lo_wdata (mem_lo_wdata),
    .mem_cp0_rdata(mem_cp0_rdata),
    .wb_inst_name (wb_inst_name),
    .memToReg     (memToReg),
    .regwrite     (regwrite),
    .HI_read      (HI_read),
    .HI_write     (HI_write),
    .LO_read      (LO_read),
    .LO_write     (LO_write),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [7:0]  inst;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [1:0]  alow;
    logic        is_load;
    logic [2:0]  ext;
    logic [31:0] hiw;
    logic [31:0] low;
    logic [31:0] cp0;
  } slot_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [7:0]  inst;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t  q[$];
  slot_t wb_slot;
  logic [31:0] m_hi, m_lo;
  int checks = 0;
  int errors = 0;
  bit done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_val(input slot_t s);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((s.rdata >> (8 * int'(s.alow))) & 32'hFF);
    h = 16'(s.rdata >> (s.alow[1] ? 16 : 0));
    case (s.ext)
      3'd1:    return 32'($signed(b));
      3'd2:    return 32'(b);
      3'd3:    return 32'($signed(h));
      3'd4:    return 32'(h);
      default: return s.rdata;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input slot_t s, input logic [31:0] hi,
                                            input logic [31:0] lo);
    case (s.inst[7:6])
      2'd0:    return s.is_load ? load_val(s) : s.result;
      2'd1:    return s.inst[4] ? hi : (s.inst[2] ? lo : 32'd0);
      2'd2:    return s.pc + 32'd8;
      default: return s.cp0;
    endcase
  endfunction

  function automatic slot_t blank(input logic [7:0] inst, input logic [4:0] waddr);
    slot_t s;
    s = '0;
    s.valid = 1'b1;
    s.inst  = inst;
    s.waddr = waddr;
    s.pc    = 32'h0040_0000;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.valid   = ($urandom_range(0, 9) != 0);
    s.inst    = 8'($urandom);
    s.pc      = $urandom;
    s.waddr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    s.result  = $urandom;
    s.rdata   = $urandom;
    s.alow    = 2'($urandom);
    s.is_load = 1'($urandom);
    s.ext     = 3'($urandom_range(0, 7));
    s.hiw     = $urandom;
    s.low     = $urandom;
    s.cp0     = $urandom;
    return s;
  endfunction

  // One clock of stimulus; pushes the commit the model predicts for this cycle, if any.
  task automatic cycle(input slot_t m, input logic st, input logic fl, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; stall = st; flush = fl;
    mem_valid = m.valid; mem_inst_name = m.inst; mem_pc = m.pc; mem_waddr = m.waddr;
    mem_result = m.result; mem_rdata = m.rdata; mem_addr_low = m.alow;
    mem_is_load = m.is_load; mem_load_ext = m.ext; mem_hi_wdata = m.hiw;
    mem_lo_wdata = m.low; mem_cp0_rdata = m.cp0;
    if (!rst && !st && wb_slot.valid) begin
      e.we    = wb_slot.inst[5] && (wb_slot.waddr != 5'd0);
      e.waddr = wb_slot.waddr;
      e.wdata = exp_wdata(wb_slot, m_hi, m_lo);
      e.pc    = wb_slot.pc;
      e.inst  = wb_slot.inst;
      e.hi    = m_hi;
      e.lo    = m_lo;
      q.push_back(e);
      if (wb_slot.inst[3]) m_hi = wb_slot.hiw;
      if (wb_slot.inst[1]) m_lo = wb_slot.low;
    end
    if (rst) begin
      wb_slot = '0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else if (fl) begin
      wb_slot.valid = 1'b0;
      wb_slot.inst  = 8'd0;
    end else if (!st) begin
      wb_slot = m;
    end
  endtask

  // Monitor: every commit the DUT presents must match the oldest predicted one.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (wb_valid && !stall && !reset) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got commit pc %h expected none at %0t", wb_pc, $time);
        end else begin
          e = q.pop_front();
          chk("rf_we", 32'(rf_we), 32'(e.we));
          if (e.we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("rf_wdata", rf_wdata, e.wdata);
          end
          chk("wb_pc", wb_pc, e.pc);
          chk("wb_inst_name", 32'(wb_inst_name), 32'(e.inst));
          chk("hi_out", hi_out, e.hi);
          chk("lo_out", lo_out, e.lo);
        end
      end else begin
        chk("rf_we_idle", 32'(rf_we), 32'd0);
        chk("missed_commit", 32'(q.size()), 32'd0);
        q.delete();
      end
    end
  end

  initial begin : stim
    slot_t idle, s;
    idle = '0;
    wb_slot = '0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_inst_name = 8'd0; mem_pc = 32'd0; mem_waddr = 5'd0;
    mem_result = 32'd0; mem_rdata = 32'd0; mem_addr_low = 2'd0; mem_is_load = 1'b0;
    mem_load_ext = 3'd0; mem_hi_wdata = 32'd0; mem_lo_wdata = 32'd0; mem_cp0_rdata = 32'd0;

    cycle(idle, 1'b0, 1'b0, 1'b1);
    cycle(idle, 1'b0, 1'b0, 1'b1);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_inst", 32'(wb_inst_name), 32'd0);
    chk("rst_pc", wb_pc, ResetPc);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);

    // Loads: LB, LBU, LHU, LH on the same word.
    s = blank(8'h20, 5'd5); s.rdata = 32'h80FF1234; s.is_load = 1'b1; s.alow = 2'd3; s.ext = 3'd1;
    cycle(s, 1'b0, 1'b0, 1'b0);
    s.ext = 3'd2;
    cycle(s, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lb_we", 32'(rf_we), 32'd1);
    chk("lb_waddr", 32'(rf_waddr), 32'd5);
    chk("lb_data", rf_wdata, 32'hFFFFFF80);
    s.alow = 2'd2; s.ext = 3'd4;
    cycle(s, 1'b0, 1'b0, 1'b0);
    #2 chk("lbu_data", rf_wdata, 32'h00000080);
    s.ext = 3'd3;
    cycle(s, 1'b0, 1'b0, 1'b0);
    #2 chk("lhu_data", rf_wdata, 32'h000080FF);

    // MULT then MFHI, MFLO.
    s = blank(8'h0A, 5'd0); s.hiw = 32'h1; s.low = 32'h2;
    cycle(s, 1'b0, 1'b0, 1'b0);
    #2 chk("lh_data", rf_wdata, 32'hFFFF80FF);
    cycle(blank(8'h70, 5'd8), 1'b0, 1'b0, 1'b0);
    cycle(blank(8'h64, 5'd9), 1'b0, 1'b0, 1'b0);
    #2;
    chk("mult_hi", hi_out, 32'h1);
    chk("mult_lo", lo_out, 32'h2);
    chk("mfhi_data", rf_wdata, 32'h1);

    // JAL, then ADDU to $0.
    s = blank(8'hA0, 5'd31); s.pc = 32'hBFC00010;
    cycle(s, 1'b0, 1'b0, 1'b0);
    #2 chk("mflo_data", rf_wdata, 32'h2);
    s = blank(8'h20, 5'd0); s.result = 32'h1234_5678;
    cycle(s, 1'b0, 1'b0, 1'b0);
    #2;
    chk("jal_data", rf_wdata, 32'hBFC00018);
    chk("jal_waddr", 32'(rf_waddr), 32'd31);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    #2 chk("addu_r0_we", 32'(rf_we), 32'd0);

    // MTHI held by a three-cycle stall.
    s = blank(8'h08, 5'd0); s.hiw = 32'hCAFE0001;
    cycle(s, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(rnd_slot(), 1'b1, 1'b0, 1'b0);
      #2;
      chk("stall_hi", hi_out, 32'h1);
      chk("stall_we", 32'(rf_we), 32'd0);
    end
    cycle(idle, 1'b0, 1'b0, 1'b0);
    #2 chk("pre_commit_hi", hi_out, 32'h1);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    #2 chk("mthi_hi", hi_out, 32'hCAFE0001);

    // Flush with stall, then reset with a valid instruction in WB.
    cycle(blank(8'h2A, 5'd7), 1'b0, 1'b0, 1'b0);
    cycle(idle, 1'b1, 1'b1, 1'b0);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    #2 chk("flush_valid", 32'(wb_valid), 32'd0);
    s = blank(8'h2A, 5'd7); s.hiw = 32'h55; s.low = 32'h66;
    cycle(s, 1'b0, 1'b0, 1'b0);
    cycle(idle, 1'b0, 1'b0, 1'b1);
    #2 chk("pre_reset_valid", 32'(wb_valid), 32'd1);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset2_valid", 32'(wb_valid), 32'd0);
    chk("reset2_pc", wb_pc, ResetPc);
    chk("reset2_hi", hi_out, 32'd0);
    chk("reset2_lo", lo_out, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(rnd_slot(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 99) == 0));
    end
    cycle(idle, 1'b0, 1'b0, 1'b0);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
    chk("final_hi", hi_out, m_hi);
    chk("final_lo", lo_out, m_lo);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
